// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed 4-digit common-anode seven-segment driver
//
// Purpose:
//   Shows a 16-bit word as four hex digits on a common-anode display. One digit is
//   lit at a time. Each digit stays lit for REFRESH_DIV clk cycles. The word, the
//   decimal-point enables and the blanking mode are captured once per frame, so a
//   scan never mixes nibbles from two different input words.
//
// Ports:
//   clk       in   system clock
//   reset_n   in   synchronous, active-low reset
//   value     in   [15:0] word to display, nibble i -> digit i (digit 0 rightmost)
//   dp_en     in   [3:0]  decimal-point enable per digit
//   blank_en  in   leading-zero blanking enable
//   an        out  [3:0]  digit anodes, active-low
//   seg       out  [6:0]  segments {CG,CF,CE,CD,CC,CB,CA}, active-low
//   dp        out  decimal point, active-low

module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp_en,
  input  logic        blank_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  generate
    if (REFRESH_DIV < 2) begin : g_bad_refresh_div
      $error("seg7_scan_driver: REFRESH_DIV must be >= 2");
    end
  endgenerate

  // Active-low segment pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    unique case (nib)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

  // Scan state
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic          valid_q, valid_d;

  // Frame registers
  logic [15:0]   value_q, value_d;
  logic [3:0]    dp_q, dp_d;
  logic          blank_q, blank_d;

  // Registered pins
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_pin_q, dp_pin_d;

  logic          tick;
  logic [3:0]    nib;
  logic          zero_above;
  logic          blanked;

  assign tick = valid_q && (cnt_q == CNT_MAX);
  assign nib  = value_q[{dig_q, 2'b00} +: 4];

  // True when the active digit and every digit to its left are zero.
  always_comb begin
    zero_above = 1'b0;
    unique case (dig_q)
      2'd1:    zero_above = (value_q[15:4] == 12'h000);
      2'd2:    zero_above = (value_q[15:8] == 8'h00);
      2'd3:    zero_above = (value_q[15:12] == 4'h0);
      default: zero_above = 1'b0;  // digit 0 always shows
    endcase
  end

  assign blanked = blank_q && zero_above;

  // Next-state logic for scan position and frame capture.
  always_comb begin
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    valid_d = valid_q;
    value_d = value_q;
    dp_d    = dp_q;
    blank_d = blank_q;

    if (!valid_q) begin
      // First cycle out of reset: take the opening frame, hold the scan at digit 0.
      valid_d = 1'b1;
      value_d = value;
      dp_d    = dp_en;
      blank_d = blank_en;
      cnt_d   = '0;
      dig_d   = 2'd0;
    end else if (tick) begin
      cnt_d = '0;
      dig_d = dig_q + 2'd1;
      if (dig_q == 2'd3) begin
        // Frame boundary: the only point where inputs are sampled.
        value_d = value;
        dp_d    = dp_en;
        blank_d = blank_en;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Pin decode from the state as held before the edge (one cycle of latency).
  always_comb begin
    an_d     = 4'b1111;
    seg_d    = 7'h7F;
    dp_pin_d = 1'b1;
    if (valid_q && !blanked) begin
      an_d     = ~(4'b0001 << dig_q);
      seg_d    = hex7(nib);
      dp_pin_d = ~dp_q[dig_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      dig_q    <= 2'd0;
      valid_q  <= 1'b0;
      value_q  <= 16'h0000;
      dp_q     <= 4'h0;
      blank_q  <= 1'b0;
      an_q     <= 4'b1111;
      seg_q    <= 7'h7F;
      dp_pin_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      valid_q  <= valid_d;
      value_q  <= value_d;
      dp_q     <= dp_d;
      blank_q  <= blank_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_pin_q <= dp_pin_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_pin_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver

module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] value;
  logic [3:0]  dp_en;
  logic        blank_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int fails  = 0;

  // Expected pins per cycle, packed {an, seg, dp}
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .value    (value),
    .dp_en    (dp_en),
    .blank_en (blank_en),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_slot(input logic [3:0] a, input logic [6:0] s, input logic d);
    repeat (4) exp_q.push_back({a, s, d});
  endtask

  task automatic push_blank();
    push_slot(4'b1111, 7'h7F, 1'b1);
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    reset_n  = 1'b0;
    value    = 16'hFFFF;
    dp_en    = 4'hF;
    blank_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      obs = {an, seg, dp};
      checks++;
      if (obs !== 12'hFFF) begin
        fails++;
        $display("FAIL reset cyc %0d: an=%b seg=%h dp=%b, expected an=1111 seg=7f dp=1",
                 i, an, seg, dp);
      end
    end
  endtask

  task automatic test_scan();
    logic [11:0] obs, exp;
    int i;
    value    = 16'h1234;
    dp_en    = 4'h0;
    blank_en = 1'b0;
    reset_n  = 1'b1;
    step();  // E0
    obs = {an, seg, dp};
    checks++;
    if (obs !== 12'hFFF) begin
      fails++;
      $display("FAIL scan_e0: an=%b seg=%h dp=%b, expected an=1111 seg=7f dp=1", an, seg, dp);
    end
    push_slot(4'b1110, 7'h19, 1'b1);
    push_slot(4'b1101, 7'h30, 1'b1);
    push_slot(4'b1011, 7'h24, 1'b1);
    push_slot(4'b0111, 7'h79, 1'b1);
    push_slot(4'b1110, 7'h19, 1'b1);
    i = 0;
    while (exp_q.size() > 0) begin
      step();
      exp = exp_q.pop_front();
      obs = {an, seg, dp};
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL scan cyc %0d: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                 i, obs[11:8], obs[7:1], obs[0], exp[11:8], exp[7:1], exp[0]);
      end
      i++;
    end
  endtask

  task automatic test_frame_coherency();
    logic [11:0] obs, exp;
    int i;
    push_slot(4'b1101, 7'h30, 1'b1);
    push_slot(4'b1011, 7'h24, 1'b1);
    push_slot(4'b0111, 7'h79, 1'b1);
    push_slot(4'b1110, 7'h21, 1'b1);
    push_slot(4'b1101, 7'h46, 1'b1);
    push_slot(4'b1011, 7'h03, 1'b1);
    push_slot(4'b0111, 7'h08, 1'b1);
    i = 0;
    while (exp_q.size() > 0) begin
      step();
      exp = exp_q.pop_front();
      obs = {an, seg, dp};
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL coherency cyc %0d: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                 i, obs[11:8], obs[7:1], obs[0], exp[11:8], exp[7:1], exp[0]);
      end
      if (i == 0) value = 16'hABCD;  // digit 1 is lit
      i++;
    end
  endtask

  task automatic test_blanking();
    logic [11:0] obs, exp;
    int i;
    value    = 16'h0050;
    blank_en = 1'b1;
    // Current ABCD frame finishes untouched
    push_slot(4'b1110, 7'h21, 1'b1);
    push_slot(4'b1101, 7'h46, 1'b1);
    push_slot(4'b1011, 7'h03, 1'b1);
    push_slot(4'b0111, 7'h08, 1'b1);
    // 0050 frame
    push_slot(4'b1110, 7'h40, 1'b1);
    push_slot(4'b1101, 7'h12, 1'b1);
    push_blank();
    push_blank();
    // 0000 frame
    push_slot(4'b1110, 7'h40, 1'b1);
    push_blank();
    push_blank();
    push_blank();
    i = 0;
    while (exp_q.size() > 0) begin
      step();
      exp = exp_q.pop_front();
      obs = {an, seg, dp};
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL blanking cyc %0d: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                 i, obs[11:8], obs[7:1], obs[0], exp[11:8], exp[7:1], exp[0]);
      end
      if (i == 16) value = 16'h0000;
      if (i == 32) begin
        value    = 16'h1234;
        blank_en = 1'b0;
        dp_en    = 4'b0100;
      end
      i++;
    end
  endtask

  task automatic test_decimal_point();
    logic [11:0] obs, exp;
    int i;
    push_slot(4'b1110, 7'h19, 1'b1);
    push_slot(4'b1101, 7'h30, 1'b1);
    push_slot(4'b1011, 7'h24, 1'b0);
    push_slot(4'b0111, 7'h79, 1'b1);
    i = 0;
    while (exp_q.size() > 0) begin
      step();
      exp = exp_q.pop_front();
      obs = {an, seg, dp};
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL dp cyc %0d: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                 i, obs[11:8], obs[7:1], obs[0], exp[11:8], exp[7:1], exp[0]);
      end
      i++;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [11:0] obs, exp;
    int i;
    push_slot(4'b1110, 7'h19, 1'b1);
    push_slot(4'b1101, 7'h30, 1'b1);
    exp_q.push_back({4'b1011, 7'h24, 1'b0});  // first cycle of digit 2
    i = 0;
    while (exp_q.size() > 0) begin
      step();
      exp = exp_q.pop_front();
      obs = {an, seg, dp};
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL pre_reset cyc %0d: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                 i, obs[11:8], obs[7:1], obs[0], exp[11:8], exp[7:1], exp[0]);
      end
      i++;
    end

    reset_n = 1'b0;
    value   = 16'hABCD;
    dp_en   = 4'h0;
    step();
    obs = {an, seg, dp};
    checks++;
    if (obs !== 12'hFFF) begin
      fails++;
      $display("FAIL mid_reset: an=%b seg=%h dp=%b, expected an=1111 seg=7f dp=1", an, seg, dp);
    end
    reset_n = 1'b1;
    step();
    obs = {an, seg, dp};
    checks++;
    if (obs !== 12'hFFF) begin
      fails++;
      $display("FAIL mid_reset_e0: an=%b seg=%h dp=%b, expected an=1111 seg=7f dp=1", an, seg, dp);
    end

    push_slot(4'b1110, 7'h21, 1'b1);
    push_slot(4'b1101, 7'h46, 1'b1);
    push_slot(4'b1011, 7'h03, 1'b1);
    push_slot(4'b0111, 7'h08, 1'b1);
    i = 0;
    while (exp_q.size() > 0) begin
      step();
      exp = exp_q.pop_front();
      obs = {an, seg, dp};
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL recovery cyc %0d: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                 i, obs[11:8], obs[7:1], obs[0], exp[11:8], exp[7:1], exp[0]);
      end
      i++;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_frame_coherency();
    test_blanking();
    test_decimal_point();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for the board's 4-digit, common-anode seven-segment display.
- Consumes the 16-bit word selected by the upstream 2:1 mux (mux2 output y) and shows it as four hex digits.
- Scans one digit at a time at a programmable refresh rate.
- Latches the input once per frame so a digit sequence never mixes old and new values.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays lit (1 kHz digit rate at 100 MHz). Legal range ≥ 2; an elaboration-time check rejects smaller values.

Ports:
- clk  input  1  system clock, 100 MHz
- reset_n  input  1  synchronous, active-low reset
- value  input  16  word to display; nibble i drives digit i (digit 0 = rightmost)
- dp_en  input  4  decimal-point enable per digit, bit i = digit i
- blank_en  input  1  1 = leading-zero blanking on
- an  output  4  digit anodes, active-low, bit i = digit i
- seg  output  7  segments, active-low, {CG,CF,CE,CD,CC,CB,CA}
- dp  output  1  decimal point, active-low

Behaviour:
- All logic is on the rising edge of clk. Reset is synchronous, active-low.
- Reset values while reset_n=0:
  - Outputs: an=4'b1111, seg=7'h7F, dp=1.
  - Internal state: refresh counter cnt=0, digit index dig=0, frame registers value_q=0, dp_q=0, blank_q=0, first-cycle flag valid_q=0.
- First edge with reset_n=1 (E0):
  - valid_q is set to 1.
  - value_q, dp_q and blank_q load from value, dp_en and blank_en.
  - Outputs stay at their reset values.
- Refresh counter: cnt counts 0 to REFRESH_DIV-1 and wraps. The edge where cnt == REFRESH_DIV-1 is the tick; dig advances on the tick, 3 wraps to 0.
- Frame reload: on a tick with dig == 3, value_q, dp_q and blank_q reload from the inputs as dig goes to 0. Input changes at any other time have no effect until the next frame.
- Outputs are registered and decoded from dig, value_q, dp_q and blank_q as held before the edge. This gives 1 cycle of latency from state to pins.
- Timing guarantees:
  - First visible digit: digit 0 appears at E1.
  - Digit dwell: each digit is lit for exactly REFRESH_DIV cycles.
  - Active anodes: exactly one an bit is low at any time, except while blanked.
- Active digit d: an = ~(4'b0001 << d), seg = hex pattern of value_q[4d+3:4d].
- Hex patterns, 0 to F in order:
  - 0-7: 40, 79, 24, 30, 19, 12, 02, 78
  - 8-F: 00, 10, 08, 03, 46, 21, 06, 0E
- dp = ~dp_q[d] whenever the digit is lit.
- Leading-zero blanking (blank_q = 1):
  - Digit d > 0 is blanked when all nibbles from d up to 3 are zero.
  - A blanked digit has an=4'b1111, seg=7'h7F, dp=1 for its whole time slot. Slot timing does not change.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Reset mid-frame: the next edge with reset_n=0 forces the reset values. Recovery follows the E0/E1 sequence, starting again at digit 0 with a fresh frame load.
- Simultaneous events: a tick on the same edge as a value change follows the frame-reload rule only; nothing else reloads.

Test Plan (REFRESH_DIV=4):
1. Hold reset_n=0 for 5 cycles with value=16'hFFFF and dp_en=4'hF -> an=4'b1111, seg=7'h7F, dp=1 on every cycle.
2. Release reset with value=16'h1234, blank_en=0 -> outputs blank at E0. Then 4 cycles each of:
   - an=1110, seg=19
   - an=1101, seg=30
   - an=1011, seg=24
   - an=0111, seg=79
   - then back to an=1110, seg=19
3. Frame coherency: change value from 16'h1234 to 16'hABCD while digit 1 is lit.
   - Digits 2 and 3 of the current frame still show 24 and 79.
   - The next frame shows 21, 46, 03, 08 on digits 0 to 3.
4. Leading-zero blanking with blank_en=1:
   - value=16'h0050: digit 0 seg=40, digit 1 seg=12, digits 2 and 3 have an=1111 for their full 4-cycle slots.
   - value=16'h0000: only digit 0 lit, seg=40.
5. Decimal point: dp_en=4'b0100 -> dp=0 only during the an=1011 slot, dp=1 in all other slots.
6. Reset mid-frame: pull reset_n low for 1 cycle during digit 2.
   - The next edge gives an=1111, seg=7F.
   - Sequence restarts: blank at E0, digit 0 of the current value from E1, 4 cycles per digit.
